// File: rtl/tinyml_cmd_dispatcher_if.sv
// Custom-instruction command/response channel. The master issues commands and accepts responses;
// the slave executes commands and returns responses.
interface tinyml_cmd_dispatcher_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_function_id;
  logic [31:0] cmd_inputs_0;
  logic [31:0] cmd_inputs_1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_outputs_0;

  modport master (
    output cmd_valid, cmd_function_id, cmd_inputs_0, cmd_inputs_1, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_outputs_0
  );

  modport slave (
    input  cmd_valid, cmd_function_id, cmd_inputs_0, cmd_inputs_1, rsp_ready,
    output cmd_ready, rsp_valid, rsp_outputs_0
  );
endinterface

// File: rtl/tinyml_cmd_dispatcher.sv
// Shares one CPU custom-instruction channel between the tinyML accelerator (fid[9]=0) and the
// user unit (fid[9]=1). Responses return strictly in command order through a registered stage.
module tinyml_cmd_dispatcher #(
  parameter int MAX_OUTSTANDING = 4,
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  tinyml_cmd_dispatcher_if.slave  cpu,
  tinyml_cmd_dispatcher_if.master accel,
  tinyml_cmd_dispatcher_if.master user,
  output logic [CW-1:0]         outstanding,
  output logic                  busy
);

  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUTSTANDING);

  logic [MAX_OUTSTANDING-1:0] tag_q;
  logic [PW-1:0]              wr_ptr_q;
  logic [PW-1:0]              rd_ptr_q;
  logic [CW-1:0]              count_q;
  logic                       rsp_valid_q;
  logic [31:0]                rsp_data_q;

  logic sel;
  logic full;
  logic empty;
  logic head;
  logic stage_free;
  logic accept;
  logic load;

  assign sel        = cpu.cmd_function_id[9];
  assign full       = (count_q == FULL_CNT);
  assign empty      = (count_q == '0);
  assign head       = tag_q[rd_ptr_q];
  assign stage_free = !rsp_valid_q || cpu.rsp_ready;

  // Operands fan out to both units; only the valids are steered.
  assign accel.cmd_function_id = cpu.cmd_function_id;
  assign accel.cmd_inputs_0    = cpu.cmd_inputs_0;
  assign accel.cmd_inputs_1    = cpu.cmd_inputs_1;
  assign user.cmd_function_id  = cpu.cmd_function_id;
  assign user.cmd_inputs_0     = cpu.cmd_inputs_0;
  assign user.cmd_inputs_1     = cpu.cmd_inputs_1;

  assign accel.cmd_valid = cpu.cmd_valid && !sel && !full;
  assign user.cmd_valid  = cpu.cmd_valid && sel && !full;
  // Full blocks acceptance even when a pop happens this cycle: no rsp-to-cmd_ready path.
  assign cpu.cmd_ready   = !full && (sel ? user.cmd_ready : accel.cmd_ready);
  assign accept          = cpu.cmd_valid && cpu.cmd_ready;

  assign accel.rsp_ready = !empty && !head && stage_free;
  assign user.rsp_ready  = !empty && head && stage_free;
  assign load            = (accel.rsp_valid && accel.rsp_ready) ||
                           (user.rsp_valid && user.rsp_ready);

  assign cpu.rsp_valid     = rsp_valid_q;
  assign cpu.rsp_outputs_0 = rsp_data_q;
  assign outstanding       = count_q;
  assign busy              = (count_q != '0) || rsp_valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      if (accept) begin
        tag_q[wr_ptr_q] <= sel;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (load) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({accept, load})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (load) begin
        rsp_valid_q <= 1'b1;
        rsp_data_q  <= head ? user.rsp_outputs_0 : accel.rsp_outputs_0;
      end else if (stage_free) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tinyml_cmd_dispatcher.sv
// Directed bench for tinyml_cmd_dispatcher: routing, ordering, full, backpressure, stall, reset.
module tb_tinyml_cmd_dispatcher;

  logic       clk;
  logic       reset;
  logic [2:0] outstanding;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  tinyml_cmd_dispatcher_if cpu_if ();
  tinyml_cmd_dispatcher_if accel_if ();
  tinyml_cmd_dispatcher_if user_if ();

  tinyml_cmd_dispatcher #(.MAX_OUTSTANDING(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .cpu         (cpu_if.slave),
    .accel       (accel_if.master),
    .user        (user_if.master),
    .outstanding (outstanding),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; checks happen mid-cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic send_cmd(input logic [9:0] fid);
    cpu_if.cmd_valid       = 1'b1;
    cpu_if.cmd_function_id = fid;
    step();
    cpu_if.cmd_valid       = 1'b0;
  endtask

  initial begin
    reset                   = 1'b1;
    cpu_if.cmd_valid        = 1'b0;
    cpu_if.cmd_function_id  = '0;
    cpu_if.cmd_inputs_0     = 32'hC0DE_0000;
    cpu_if.cmd_inputs_1     = 32'hC0DE_0001;
    cpu_if.rsp_ready        = 1'b0;
    accel_if.cmd_ready      = 1'b0;
    accel_if.rsp_valid      = 1'b0;
    accel_if.rsp_outputs_0  = '0;
    user_if.cmd_ready       = 1'b0;
    user_if.rsp_valid       = 1'b0;
    user_if.rsp_outputs_0   = '0;
    step();
    step();
    reset = 1'b0;
    settle();

    // Reset state
    check_val("rst_rsp_valid",   32'(cpu_if.rsp_valid), 32'd0);
    check_val("rst_rsp_data",    cpu_if.rsp_outputs_0,  32'd0);
    check_val("rst_outstanding", 32'(outstanding),      32'd0);
    check_val("rst_busy",        32'(busy),             32'd0);
    check_val("rst_cmd_ready",   32'(cpu_if.cmd_ready), 32'd0);
    check_val("rst_accel_cv",    32'(accel_if.cmd_valid), 32'd0);
    check_val("rst_user_cv",     32'(user_if.cmd_valid),  32'd0);
    check_val("rst_accel_rr",    32'(accel_if.rsp_ready), 32'd0);
    check_val("rst_user_rr",     32'(user_if.rsp_ready),  32'd0);

    // Single accel command
    accel_if.cmd_ready     = 1'b1;
    user_if.cmd_ready      = 1'b1;
    cpu_if.rsp_ready       = 1'b1;
    cpu_if.cmd_valid       = 1'b1;
    cpu_if.cmd_function_id = 10'h005;
    settle();
    check_val("t1_accel_cv",   32'(accel_if.cmd_valid), 32'd1);
    check_val("t1_user_cv",    32'(user_if.cmd_valid),  32'd0);
    check_val("t1_cmd_ready",  32'(cpu_if.cmd_ready),   32'd1);
    check_val("t1_fid_fanout", 32'(user_if.cmd_function_id), 32'h005);
    check_val("t1_in0_fanout", accel_if.cmd_inputs_0,   32'hC0DE_0000);
    step();
    cpu_if.cmd_valid = 1'b0;
    settle();
    check_val("t1_accel_cv_drop", 32'(accel_if.cmd_valid), 32'd0);
    check_val("t1_outstanding1",  32'(outstanding),        32'd1);
    check_val("t1_busy",          32'(busy),               32'd1);
    check_val("t1_accel_rr",      32'(accel_if.rsp_ready), 32'd1);
    step();
    accel_if.rsp_valid     = 1'b1;
    accel_if.rsp_outputs_0 = 32'h1234_5678;
    settle();
    check_val("t1_rsp_valid_pre", 32'(cpu_if.rsp_valid), 32'd0);
    step();
    accel_if.rsp_valid = 1'b0;
    settle();
    check_val("t1_rsp_valid",    32'(cpu_if.rsp_valid), 32'd1);
    check_val("t1_rsp_data",     cpu_if.rsp_outputs_0,  32'h1234_5678);
    check_val("t1_outstanding0", 32'(outstanding),      32'd0);
    step();
    check_val("t1_rsp_clear", 32'(cpu_if.rsp_valid), 32'd0);
    check_val("t1_idle_busy", 32'(busy),             32'd0);

    // Ordering: accel then user, user answers first
    send_cmd(10'h010);
    cpu_if.cmd_valid       = 1'b1;
    cpu_if.cmd_function_id = 10'h210;
    settle();
    check_val("t2_user_cv", 32'(user_if.cmd_valid), 32'd1);
    step();
    cpu_if.cmd_valid = 1'b0;
    user_if.rsp_valid     = 1'b1;
    user_if.rsp_outputs_0 = 32'h0000_BBBB;
    settle();
    check_val("t2_outstanding2", 32'(outstanding),       32'd2);
    check_val("t2_user_rr_held", 32'(user_if.rsp_ready), 32'd0);
    check_val("t2_accel_rr",     32'(accel_if.rsp_ready), 32'd1);
    for (int i = 0; i < 3; i++) step();
    check_val("t2_user_rr_held3", 32'(user_if.rsp_ready), 32'd0);
    check_val("t2_no_rsp_yet",    32'(cpu_if.rsp_valid),  32'd0);
    accel_if.rsp_valid     = 1'b1;
    accel_if.rsp_outputs_0 = 32'h0000_AAAA;
    step();
    accel_if.rsp_valid = 1'b0;
    settle();
    check_val("t2_first_valid", 32'(cpu_if.rsp_valid), 32'd1);
    check_val("t2_first_data",  cpu_if.rsp_outputs_0,  32'h0000_AAAA);
    check_val("t2_user_rr",     32'(user_if.rsp_ready), 32'd1);
    step();
    user_if.rsp_valid = 1'b0;
    settle();
    check_val("t2_second_valid", 32'(cpu_if.rsp_valid), 32'd1);
    check_val("t2_second_data",  cpu_if.rsp_outputs_0,  32'h0000_BBBB);
    check_val("t2_outstanding0", 32'(outstanding),      32'd0);
    step();
    check_val("t2_rsp_clear", 32'(cpu_if.rsp_valid), 32'd0);

    // Full: four accel commands with no responses
    cpu_if.cmd_valid       = 1'b1;
    cpu_if.cmd_function_id = 10'h001;
    for (int i = 0; i < 4; i++) step();
    check_val("t3_outstanding4", 32'(outstanding),        32'd4);
    check_val("t3_full_ready",   32'(cpu_if.cmd_ready),   32'd0);
    check_val("t3_full_cv",      32'(accel_if.cmd_valid), 32'd0);
    accel_if.rsp_valid     = 1'b1;
    accel_if.rsp_outputs_0 = 32'h0000_0011;
    settle();
    check_val("t3_no_bypass", 32'(cpu_if.cmd_ready), 32'd0);
    step();
    cpu_if.cmd_valid = 1'b0;
    settle();
    check_val("t3_ready_back",   32'(cpu_if.cmd_ready), 32'd1);
    check_val("t3_outstanding3", 32'(outstanding),      32'd3);
    for (int i = 0; i < 3; i++) step();
    accel_if.rsp_valid = 1'b0;
    check_val("t3_drained", 32'(outstanding), 32'd0);
    step();
    check_val("t3_idle", 32'(busy), 32'd0);

    // Backpressure: two responses pending, upstream stalled
    send_cmd(10'h020);
    send_cmd(10'h220);
    cpu_if.rsp_ready       = 1'b0;
    accel_if.rsp_valid     = 1'b1;
    accel_if.rsp_outputs_0 = 32'h0000_00A1;
    user_if.rsp_valid      = 1'b1;
    user_if.rsp_outputs_0  = 32'h0000_00B2;
    step();
    accel_if.rsp_valid = 1'b0;
    settle();
    check_val("t4_valid",     32'(cpu_if.rsp_valid),   32'd1);
    check_val("t4_data",      cpu_if.rsp_outputs_0,    32'h0000_00A1);
    check_val("t4_accel_rr0", 32'(accel_if.rsp_ready), 32'd0);
    check_val("t4_user_rr0",  32'(user_if.rsp_ready),  32'd0);
    step();
    check_val("t4_data_stable", cpu_if.rsp_outputs_0,   32'h0000_00A1);
    check_val("t4_user_rr_hold", 32'(user_if.rsp_ready), 32'd0);
    cpu_if.rsp_ready = 1'b1;
    settle();
    check_val("t4_user_rr1", 32'(user_if.rsp_ready), 32'd1);
    step();
    user_if.rsp_valid = 1'b0;
    settle();
    check_val("t4_second_valid", 32'(cpu_if.rsp_valid), 32'd1);
    check_val("t4_second_data",  cpu_if.rsp_outputs_0,  32'h0000_00B2);
    step();
    check_val("t4_done_valid", 32'(cpu_if.rsp_valid), 32'd0);
    check_val("t4_done_out",   32'(outstanding),      32'd0);

    // Target stall: user unit not ready
    user_if.cmd_ready      = 1'b0;
    cpu_if.cmd_valid       = 1'b1;
    cpu_if.cmd_function_id = 10'h3FF;
    settle();
    check_val("t5_cmd_ready", 32'(cpu_if.cmd_ready),   32'd0);
    check_val("t5_accel_cv",  32'(accel_if.cmd_valid), 32'd0);
    check_val("t5_user_cv",   32'(user_if.cmd_valid),  32'd1);
    step();
    check_val("t5_no_push", 32'(outstanding), 32'd0);
    cpu_if.cmd_valid  = 1'b0;
    user_if.cmd_ready = 1'b1;

    // Reset mid-flight
    send_cmd(10'h001);
    send_cmd(10'h002);
    send_cmd(10'h003);
    settle();
    check_val("t6_outstanding3", 32'(outstanding), 32'd3);
    cpu_if.rsp_ready       = 1'b0;
    accel_if.rsp_valid     = 1'b1;
    accel_if.rsp_outputs_0 = 32'h0000_0077;
    step();
    check_val("t6_pre_rst_valid", 32'(cpu_if.rsp_valid), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    settle();
    check_val("t6_outstanding0", 32'(outstanding),        32'd0);
    check_val("t6_rsp_valid0",   32'(cpu_if.rsp_valid),   32'd0);
    check_val("t6_busy0",        32'(busy),               32'd0);
    check_val("t6_rsp_data0",    cpu_if.rsp_outputs_0,    32'd0);
    check_val("t6_accel_rr_held", 32'(accel_if.rsp_ready), 32'd0);
    send_cmd(10'h004);
    accel_if.rsp_outputs_0 = 32'h0000_0099;
    cpu_if.rsp_ready       = 1'b1;
    settle();
    check_val("t6_new_out1", 32'(outstanding), 32'd1);
    step();
    accel_if.rsp_valid = 1'b0;
    settle();
    check_val("t6_new_valid", 32'(cpu_if.rsp_valid), 32'd1);
    check_val("t6_new_data",  cpu_if.rsp_outputs_0,  32'h0000_0099);
    check_val("t6_new_out0",  32'(outstanding),      32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/tinyml_cmd_dispatcher.md
# tinyml_cmd_dispatcher

Shares the CPU custom-instruction command/response channel between the tinyML accelerator (function ID bit 9 = 0) and the user custom-instruction unit (function ID bit 9 = 1). It routes each accepted command to its target and records the target in an in-order tag FIFO. Responses are returned upstream strictly in command order through a registered output stage. It sits between the CPU custom-instruction port and the two execution units, replacing the direct wiring inside the tinyML top level.

## Interface
- MAX_OUTSTANDING, 4, maximum number of commands accepted but not yet answered; power of 2, at least 2
- CW, $clog2(MAX_OUTSTANDING)+1, width of the outstanding count (derived, not overridden)

- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  upstream command valid
- cmd_function_id  in  10  function ID; bit 9 selects target
- cmd_inputs_0  in  32  operand 0
- cmd_inputs_1  in  32  operand 1
- cmd_ready  out  1  upstream command ready
- rsp_valid  out  1  upstream response valid (registered)
- rsp_outputs_0  out  32  upstream response data (registered)
- rsp_ready  in  1  upstream response ready
- accel_cmd_valid  out  1  command valid to accelerator
- accel_cmd_ready  in  1  accelerator command ready
- accel_rsp_valid  in  1  accelerator response valid
- accel_rsp_outputs_0  in  32  accelerator response data
- accel_rsp_ready  out  1  accelerator response ready
- user_cmd_valid  out  1  command valid to user unit
- user_cmd_ready  in  1  user unit command ready
- user_rsp_valid  in  1  user unit response valid
- user_rsp_outputs_0  in  32  user unit response data
- user_rsp_ready  out  1  user unit response ready
- outstanding  out  CW  commands in flight (tag FIFO occupancy)
- busy  out  1  outstanding != 0 or rsp_valid

cmd_function_id and cmd_inputs_0/1 fan out unregistered to both units. Only the valid signals are steered.

## Operation
- sel = cmd_function_id[9]. full = (outstanding == MAX_OUTSTANDING). empty = (outstanding == 0).
- accel_cmd_valid = cmd_valid & !sel & !full.
- user_cmd_valid = cmd_valid & sel & !full.
- cmd_ready = !full & (sel ? user_cmd_ready : accel_cmd_ready).
- Accept = cmd_valid & cmd_ready. On accept, sel is pushed into the tag FIFO.
- There is no same-cycle bypass. When full, cmd_ready stays 0 even if a pop occurs in that cycle, so there is no combinational path from the response side to cmd_ready.
- head = tag FIFO read entry. stage_free = !rsp_valid | rsp_ready.
- accel_rsp_ready = !empty & head==0 & stage_free.
- user_rsp_ready = !empty & head==1 & stage_free.
- Load = (selected unit's rsp_valid & rsp_ready). On load:
  - the stage captures that unit's data;
  - rsp_valid is set to 1;
  - the tag FIFO pops.
- If stage_free and no load occurs, rsp_valid clears.
- The non-head unit is held with ready=0 even if its response is valid. The dispatcher never reorders.
- When the FIFO is empty, both rsp_ready outputs are 0. A response with no matching command is held, not dropped.
- outstanding: +1 on accept only, -1 on load only, unchanged on both or neither. Wrap-around of the FIFO pointers is modulo MAX_OUTSTANDING.

## Timing
- Reset values: rsp_valid=0, rsp_outputs_0=0, outstanding=0, busy=0, FIFO pointers=0.
- The ready/valid outputs are combinational from current inputs and state. With no inputs asserted after reset, all are 0.
- Command path latency is 0 cycles (combinational pass-through).
- Response latency is 1 cycle: a unit response loaded at edge N is presented as rsp_valid from edge N+1.
- Throughput: with rsp_ready held at 1, one response per cycle.
- A unit that answers in the same cycle its command is accepted is not taken that cycle, because the FIFO was empty at evaluation. The unit must hold rsp_valid until ready, per its handshake.
- Upstream: once rsp_valid=1, rsp_outputs_0 is stable until the cycle rsp_ready=1.
- Reset asserted mid-operation clears all state in the next cycle. In-flight unit responses are then held (ready=0) until new commands are issued. Both units are reset together with the dispatcher.

## Test plan
- Single accel command: fid=0x005, accel_cmd_ready=1; accel returns 0x1234_5678 two cycles later. Expect accel_cmd_valid high for 1 cycle, outstanding 1→0, and rsp_valid with 0x1234_5678 exactly one cycle after the accel handshake.
- Ordering: issue accel (fid 0x010), then user (fid 0x210). The user unit responds 0xBBBB first, the accel 0xAAAA three cycles later. Expect user_rsp_ready=0 until the accel response is loaded; upstream receives 0xAAAA then 0xBBBB on consecutive cycles.
- Full: MAX_OUTSTANDING=4, issue 4 commands with no responses. Expect cmd_ready=0 on the 5th while outstanding=4. After one response is loaded, cmd_ready returns to 1 the following cycle.
- Backpressure: rsp_ready=0 with 2 responses pending. Expect rsp_valid=1 with the first data stable, both unit ready outputs 0. Release rsp_ready and expect both responses on back-to-back cycles.
- Target stall: user_cmd_ready=0 with cmd_valid and fid=0x3FF. Expect cmd_ready=0, accel_cmd_valid=0, user_cmd_valid=1, and no FIFO push.
- Reset mid-flight: 3 commands outstanding, assert reset 1 cycle. Expect outstanding=0, rsp_valid=0, busy=0 next cycle, and a new command processed normally afterwards.
